spi_slave_reg_bridge: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 19 +
 rtl/spi_slave_shifter.sv | 97 +++++++++
 rtl/spi_slave_reg_bridge.sv | 142 ++++++++++++++
 tb/tb_spi_slave_reg_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM state encoding for the SPI-slave register bridge.
package spi_slave_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CTRL_WR_BIT = 2;
  localparam int unsigned NUM_STATES  = 8;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_ADDR_H   = 8'b0000_0010,
    ST_ADDR_L   = 8'b0000_0100,
    ST_CONTROL  = 8'b0000_1000,
    ST_WRITE    = 8'b0001_0000,
    ST_READ_LEN = 8'b0010_0000,
    ST_READ     = 8'b0100_0000,
    ST_OVER     = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI pin synchronizers, sclk/scs edge detection and the rx/tx byte shift registers.
module spi_slave_shifter
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              scs,
  input  logic              mosi,
  input  logic              tx_load,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              byte_valid_c,
  output logic [BYTE_W-1:0] rx_byte_c,
  output logic              scs_rise_c,
  output logic              scs_fall_c,
  output logic              miso,
  output logic              miso_oe
);

  localparam int unsigned CNT_W = $clog2(BYTE_W);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] scs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   scs_q;
  logic                   armed;
  logic [CNT_W-1:0]       bit_cnt;
  logic [BYTE_W-1:0]      rx_shift;
  logic [BYTE_W-1:0]      tx_shift;
  logic                   sclk_s;
  logic                   scs_s;
  logic                   mosi_s;
  logic                   sclk_rise_c;
  logic                   sclk_fall_c;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign scs_s  = scs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // sclk edges only count while the slave is selected
  assign sclk_rise_c  = sclk_s & ~sclk_q & ~scs_s;
  assign sclk_fall_c  = ~sclk_s & sclk_q & ~scs_s;
  assign byte_valid_c = sclk_rise_c && (bit_cnt == CNT_W'(BYTE_W - 1));
  assign rx_byte_c    = {rx_shift[BYTE_W-2:0], mosi_s};
  assign scs_rise_c   = scs_s & ~scs_q;
  // a select already low at reset release must not start a frame
  assign scs_fall_c   = ~scs_s & scs_q & armed;
  assign miso         = tx_shift[BYTE_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      scs_sync  <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      scs_sync  <= {scs_sync[SYNC_STAGES-2:0], scs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q   <= 1'b0;
      scs_q    <= 1'b1;
      armed    <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_oe  <= 1'b0;
    end else begin
      sclk_q  <= sclk_s;
      scs_q   <= scs_s;
      miso_oe <= ~scs_s;
      if (scs_s) begin
        armed    <= 1'b1;
        bit_cnt  <= '0;
        tx_shift <= '0;
      end else begin
        if (sclk_rise_c) begin
          rx_shift <= rx_byte_c;
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
        // no shift on the falling edge that follows a byte boundary: the MSB must stay up
        if (tx_load) begin
          tx_shift <= tx_byte;
        end else if (sclk_fall_c && (bit_cnt != '0)) begin
          tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_slave_reg_bridge.sv
// SPI-slave frame decoder driving a byte-wide register port: ADDR_H, ADDR_L, CONTROL, then data.
module spi_slave_reg_bridge
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              scs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [BYTE_W-1:0] reg_wr_data,
  output logic              reg_rd_en,
  input  logic [BYTE_W-1:0] reg_rd_data,
  output logic              busy,
  output logic              frame_done
);

  logic              byte_valid_c;
  logic [BYTE_W-1:0] rx_byte_c;
  logic              scs_rise_c;
  logic              scs_fall_c;
  logic              tx_load_c;
  logic [BYTE_W-1:0] tx_byte_c;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] addr_hi_q, addr_hi_d;
  logic [BYTE_W-1:0] rd_rem_q, rd_rem_d;
  logic              rd_load_q;
  logic [ADDR_W-1:0] addr_d;
  logic              wr_en_d;
  logic [BYTE_W-1:0] wr_data_d;
  logic              rd_en_d;
  logic              frame_done_d;

  spi_slave_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .scs          (scs),
    .mosi         (mosi),
    .tx_load      (tx_load_c),
    .tx_byte      (tx_byte_c),
    .byte_valid_c (byte_valid_c),
    .rx_byte_c    (rx_byte_c),
    .scs_rise_c   (scs_rise_c),
    .scs_fall_c   (scs_fall_c),
    .miso         (miso),
    .miso_oe      (miso_oe)
  );

  // read data arrives the cycle after the strobe; OVER keeps the tx register at zero
  assign tx_load_c = rd_load_q || (state_q == ST_OVER);
  assign tx_byte_c = rd_load_q ? reg_rd_data : '0;

  always_comb begin
    state_d      = state_q;
    addr_hi_d    = addr_hi_q;
    addr_d       = reg_addr;
    rd_rem_d     = rd_rem_q;
    wr_en_d      = 1'b0;
    wr_data_d    = reg_wr_data;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;

    if (reg_wr_en || reg_rd_en) addr_d = reg_addr + ADDR_W'(1);
    if (reg_rd_en) rd_rem_d = rd_rem_q - BYTE_W'(1);

    if (scs_rise_c) begin
      state_d      = ST_IDLE;
      frame_done_d = state_q inside {ST_WRITE, ST_READ_LEN, ST_READ, ST_OVER};
    end else begin
      case (state_q)
        ST_IDLE:    if (scs_fall_c) state_d = ST_ADDR_H;
        ST_ADDR_H:  if (byte_valid_c) begin
                      addr_hi_d = rx_byte_c;
                      state_d   = ST_ADDR_L;
                    end
        ST_ADDR_L:  if (byte_valid_c) begin
                      addr_d  = ADDR_W'({addr_hi_q, rx_byte_c});
                      state_d = ST_CONTROL;
                    end
        ST_CONTROL: if (byte_valid_c) begin
                      state_d = rx_byte_c[CTRL_WR_BIT] ? ST_WRITE : ST_READ_LEN;
                    end
        ST_WRITE:   if (byte_valid_c) begin
                      wr_en_d   = 1'b1;
                      wr_data_d = rx_byte_c;
                    end
        ST_READ_LEN: if (byte_valid_c) begin
                      rd_rem_d = rx_byte_c;
                      if (rx_byte_c != '0) begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                      end else begin
                        state_d = ST_OVER;
                      end
                    end
        ST_READ:    if (byte_valid_c) begin
                      if (rd_rem_q != '0) rd_en_d = 1'b1;
                      else                state_d = ST_OVER;
                    end
        ST_OVER:    state_d = ST_OVER;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= '0;
      rd_rem_q    <= '0;
      rd_load_q   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      rd_rem_q    <= rd_rem_d;
      rd_load_q   <= reg_rd_en;
      reg_addr    <= addr_d;
      reg_wr_en   <= wr_en_d;
      reg_wr_data <= wr_data_d;
      reg_rd_en   <= rd_en_d;
      busy        <= (state_d != ST_IDLE);
      frame_done  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Scoreboard bench: an SPI master drives frames, a reference model queues expected port traffic.
module tb_spi_slave_reg_bridge;

  localparam int HALF = 50;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        scs;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;
  logic        busy;
  logic        frame_done;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          fd_pending = 0;
  logic [7:0]  dev_mem [65536];
  logic [7:0]  ref_mem [65536];
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  fb[$];

  spi_slave_reg_bridge #(
    .ADDR_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .scs         (scs),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .reg_addr    (reg_addr),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // register file on the far side of the port: read data one cycle after the strobe
  initial reg_rd_data = 8'h00;
  always @(posedge clk) begin
    if (reg_wr_en) dev_mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= dev_mem[reg_addr];
  end

  // monitor: pops the scoreboard whenever the DUT strobes
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (reg_wr_en) begin
          chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(reg_addr), 32'(w.addr));
            chk("wr_data", 32'(reg_wr_data), 32'(w.data));
          end
        end
        if (reg_rd_en) begin
          chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) chk("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
        if (frame_done) begin
          chk("fd_expected", 32'(fd_pending > 0), 32'd1);
          if (fd_pending > 0) fd_pending--;
        end
      end
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      mosi = tx[7-b];
      #(HALF);
      sclk = 1'b1;
      rx[7-b] = miso;
      #(HALF);
      sclk = 1'b0;
    end
  endtask

  // sends fb[] as one frame; expectations come from the frame rules applied to ref_mem
  task automatic run_frame(input int abort_bits, input bit keep_open);
    logic [15:0] a0;
    logic [7:0]  ctl;
    logic [7:0]  rx;
    logic [7:0]  em;
    logic        is_wr;
    int          len;
    int          n;
    wr_t         w;
    n = fb.size();
    a0 = 16'h0000;
    is_wr = 1'b0;
    len = 0;
    if (n >= 2) a0 = {fb[0], fb[1]};
    if (n >= 3) begin
      ctl = fb[2];
      is_wr = ctl[2];
    end
    if (n >= 4) len = int'(fb[3]);
    scs = 1'b0;
    #(2*HALF);
    for (int i = 0; i < n; i++) begin
      em = 8'h00;
      if (!is_wr && i >= 4 && (i - 4) < len) em = ref_mem[16'(a0 + 16'(i - 4))];
      if (is_wr && i >= 3) begin
        w.addr = 16'(a0 + 16'(i - 3));
        w.data = fb[i];
        exp_wr.push_back(w);
        ref_mem[w.addr] = fb[i];
      end
      if (!is_wr && i == 3 && len > 0) exp_rd.push_back(a0);
      if (!is_wr && i >= 4 && (i - 3) < len) exp_rd.push_back(16'(a0 + 16'(i - 3)));
      spi_xfer(fb[i], 8, rx);
      chk($sformatf("miso_byte%0d", i), 32'(rx), 32'(em));
    end
    if (abort_bits > 0) spi_xfer(8'($urandom), abort_bits, rx);
    if (!keep_open) begin
      #(HALF);
      if (n >= 3) fd_pending++;
      scs = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      chk("busy_after_scs", 32'(busy), 32'd0);
      chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      #(2*HALF);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  ctl;
    int          cnt;
    int          ab;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[16'h0010] = 8'hA1; ref_mem[16'h0010] = 8'hA1;
    dev_mem[16'h0011] = 8'hB2; ref_mem[16'h0011] = 8'hB2;
    dev_mem[16'h0012] = 8'hC3; ref_mem[16'h0012] = 8'hC3;

    rst = 1'b0;
    sclk = 1'b0;
    scs = 1'b1;
    mosi = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // write burst
    fb = '{8'h12, 8'h34, 8'h04, 8'hAA, 8'h55};
    run_frame(0, 1'b0);
    // read burst of three
    fb = '{8'h00, 8'h10, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, 1'b0);
    // zero read length returns zeros
    fb = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h5A, 8'hA5};
    run_frame(0, 1'b0);
    // address wrap on write, then read back across the wrap
    fb = '{8'hFF, 8'hFF, 8'h04, 8'h3C, 8'hC3};
    run_frame(0, 1'b0);
    fb = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00};
    run_frame(0, 1'b0);
    // partial byte then scs high: no strobe for the fragment
    fb = '{8'h20, 8'h00, 8'h04, 8'h5A};
    run_frame(4, 1'b0);
    fb = '{8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_frame(0, 1'b0);

    // reset in the middle of a read
    fb = '{8'h00, 8'h40, 8'h00, 8'h05, 8'hFF, 8'hFF};
    run_frame(0, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_reg_addr", 32'(reg_addr), 32'd0);
    chk("midrst_miso_oe", 32'(miso_oe), 32'd0);
    chk("midrst_rd_queue", 32'(exp_rd.size()), 32'd0);
    scs = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    fb = '{8'h00, 8'h40, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, 1'b0);

    // randomized frames over a small address window plus the top of the map
    for (int f = 0; f < 30; f++) begin
      fb.delete();
      if ($urandom_range(0, 3) == 0) a = 16'(16'hFFFC + 16'($urandom_range(0, 3)));
      else                           a = 16'($urandom_range(0, 255));
      fb.push_back(a[15:8]);
      fb.push_back(a[7:0]);
      ctl = 8'($urandom);
      ctl[2] = 1'($urandom_range(0, 1));
      fb.push_back(ctl);
      if (ctl[2]) begin
        cnt = $urandom_range(0, 5);
        for (int k = 0; k < cnt; k++) fb.push_back(8'($urandom));
      end else begin
        cnt = $urandom_range(0, 5);
        fb.push_back(8'(cnt));
        cnt = cnt + $urandom_range(0, 2);
        for (int k = 0; k < cnt; k++) fb.push_back(8'($urandom));
      end
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(ab, 1'b0);
    end

    chk("frame_done_all_seen", 32'(fd_pending), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
